// File: rtl/nios_job_sequencer.sv
// Host-side job sequencer for the Nios mailbox: loads a job into dual-port RAM, hands it to the Nios
// through the GPI/GPO lines, clears the Nios state and streams the processed words back out.
module nios_job_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                sys_clk_main_fpga,
  input  logic                sys_reset,
  input  logic                job_start,
  input  logic [ADDR_W:0]     job_len,
  output logic                job_ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                job_done,
  output logic [1:0]          job_status,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_clken,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic [DATA_W/8-1:0] ram_byteenable,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                gpi_data_proc_request,
  output logic                gpi_clear_nios_state,
  input  logic                gpo_nios_busy,
  input  logic                gpo_nios_done,
  input  logic                gpo_nios_error
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_NIOS_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_BAD_LEN  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_REQ, S_WAIT, S_CLEAR, S_RD_ADDR, S_RD_WAIT, S_RD_OUT, S_REPORT
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W:0]     len, len_n, wcnt, wcnt_n, wcnt_inc;
  logic [TCNT_W-1:0]   tcnt, tcnt_n;
  logic [1:0]          status, status_n;
  logic                busy_p1, done_p1, error_p1;
  logic                last_word, nios_idle;

  logic                cs_n, write_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n, out_data_n;

  assign wcnt_inc  = wcnt + CNT_ONE;
  assign last_word = (wcnt == len - CNT_ONE);
  assign nios_idle = !(busy_p1 || done_p1 || error_p1);

  always_comb begin
    state_n    = state;
    len_n      = len;
    wcnt_n     = wcnt;
    tcnt_n     = tcnt;
    status_n   = status;
    cs_n       = 1'b0;
    write_n    = 1'b0;
    addr_n     = ram_address;
    wdata_n    = ram_writedata;
    out_data_n = out_data;
    case (state)
      S_IDLE: begin
        if (job_start) begin
          len_n    = job_len;
          wcnt_n   = '0;
          tcnt_n   = '0;
          status_n = ST_OK;
          if (job_len == '0 || job_len > MAX_LEN) begin
            status_n = ST_BAD_LEN;
            state_n  = S_REPORT;
          end else begin
            state_n = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          cs_n    = 1'b1;
          write_n = 1'b1;
          addr_n  = wcnt[ADDR_W-1:0];
          wdata_n = in_data;
          if (last_word) begin
            wcnt_n  = '0;
            tcnt_n  = '0;
            state_n = S_REQ;
          end else begin
            wcnt_n = wcnt_inc;
          end
        end
      end
      S_REQ: begin
        // A done/error seen on the last budget cycle is still honoured in WAIT.
        if (!(done_p1 || error_p1) && tcnt == TCNT_LAST) begin
          status_n = ST_TIMEOUT;
          tcnt_n   = '0;
          state_n  = S_CLEAR;
        end else begin
          tcnt_n = tcnt + TCNT_ONE;
          if (!nios_idle) state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (error_p1) begin
          status_n = ST_NIOS_ERR;
          tcnt_n   = '0;
          state_n  = S_CLEAR;
        end else if (done_p1) begin
          status_n = ST_OK;
          tcnt_n   = '0;
          state_n  = S_CLEAR;
        end else if (tcnt >= TCNT_LAST) begin
          status_n = ST_TIMEOUT;
          tcnt_n   = '0;
          state_n  = S_CLEAR;
        end else begin
          tcnt_n = tcnt + TCNT_ONE;
        end
      end
      S_CLEAR: begin
        if (nios_idle) begin
          wcnt_n = '0;
          if (status == ST_OK) begin
            state_n = S_RD_ADDR;
            cs_n    = 1'b1;
            addr_n  = '0;
          end else begin
            state_n = S_REPORT;
          end
        end else if (tcnt == TCNT_LAST) begin
          status_n = ST_TIMEOUT;
          state_n  = S_REPORT;
        end else begin
          tcnt_n = tcnt + TCNT_ONE;
        end
      end
      S_RD_ADDR: state_n = S_RD_WAIT;
      S_RD_WAIT: begin
        out_data_n = ram_readdata;
        state_n    = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (out_valid && out_ready) begin
          if (last_word) begin
            state_n = S_REPORT;
          end else begin
            wcnt_n  = wcnt_inc;
            cs_n    = 1'b1;
            addr_n  = wcnt_inc[ADDR_W-1:0];
            state_n = S_RD_ADDR;
          end
        end
      end
      S_REPORT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Registered state, GPO sample stage and state-decoded outputs
  always_ff @(posedge sys_clk_main_fpga) begin
    if (sys_reset) begin
      state                 <= S_IDLE;
      len                   <= '0;
      wcnt                  <= '0;
      tcnt                  <= '0;
      status                <= ST_OK;
      busy_p1               <= 1'b0;
      done_p1               <= 1'b0;
      error_p1              <= 1'b0;
      job_ready             <= 1'b1;
      in_ready              <= 1'b0;
      out_valid             <= 1'b0;
      out_data              <= '0;
      job_done              <= 1'b0;
      job_status            <= 2'b00;
      ram_address           <= '0;
      ram_chipselect        <= 1'b0;
      ram_clken             <= 1'b0;
      ram_write             <= 1'b0;
      ram_writedata         <= '0;
      ram_byteenable        <= '0;
      gpi_data_proc_request <= 1'b0;
      gpi_clear_nios_state  <= 1'b0;
    end else begin
      state                 <= state_n;
      len                   <= len_n;
      wcnt                  <= wcnt_n;
      tcnt                  <= tcnt_n;
      status                <= status_n;
      busy_p1               <= gpo_nios_busy;
      done_p1               <= gpo_nios_done;
      error_p1              <= gpo_nios_error;
      job_ready             <= (state_n == S_IDLE);
      in_ready              <= (state_n == S_LOAD);
      out_valid             <= (state_n == S_RD_OUT);
      out_data              <= out_data_n;
      job_done              <= (state_n == S_REPORT);
      job_status            <= (state_n == S_REPORT) ? status_n : 2'b00;
      ram_address           <= addr_n;
      ram_chipselect        <= cs_n;
      ram_clken             <= cs_n;
      ram_write             <= write_n;
      ram_writedata         <= wdata_n;
      ram_byteenable        <= cs_n ? '1 : '0;
      gpi_data_proc_request <= (state_n == S_REQ) || (state_n == S_WAIT);
      gpi_clear_nios_state  <= (state_n == S_CLEAR);
    end
  end

endmodule
